mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_arb_rr2.sv | 17 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: lock-state encoding and port ids.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic ARB_PORT_CPU    = 1'b0;
    localparam logic ARB_PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: on contention the port that did not win last time is granted.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (last == ARB_PORT_LOADER) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter with round robin, per-port lock and a 1-cycle read response path.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | round-robin between both ports
// ARB_LOCK0 | port 0 owns the memory; port 1 stalls
// ARB_LOCK1 | port 1 owns the memory; port 0 stalls
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  r0Strobe,
    input  logic [ADDR_WIDTH-1:0] r0Addr,
    input  logic                  r0Write,
    input  logic [DATA_WIDTH-1:0] r0WData,
    input  logic                  r0Lock,
    output logic                  r0Grant,
    output logic                  r0Valid,
    output logic [DATA_WIDTH-1:0] r0RData,

    input  logic                  r1Strobe,
    input  logic [ADDR_WIDTH-1:0] r1Addr,
    input  logic                  r1Write,
    input  logic [DATA_WIDTH-1:0] r1WData,
    input  logic                  r1Lock,
    output logic                  r1Grant,
    output logic                  r1Valid,
    output logic [DATA_WIDTH-1:0] r1RData,

    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic [DATA_WIDTH-1:0] memDataRead
);

    arb_state_t r_lock_state;
    logic       r_last_grant;
    logic       r_rsp_pending;
    logic       r_rsp_port;

    logic [1:0] w_req;
    logic [1:0] w_rr_gnt;
    logic [1:0] w_gnt;
    logic       w_sel;

    assign w_req = {r1Strobe, r0Strobe};

    arb_rr2 u_rr (
        .req  (w_req),
        .last (r_last_grant),
        .gnt  (w_rr_gnt)
    );

    // Grants are gated by reset so nothing reaches the memory while reset is held.
    always_comb begin
        w_gnt = 2'b00;
        case (r_lock_state)
            ARB_IDLE:  w_gnt = w_rr_gnt;
            ARB_LOCK0: w_gnt = {1'b0, r0Strobe};
            ARB_LOCK1: w_gnt = {r1Strobe, 1'b0};
            default:   w_gnt = 2'b00;
        endcase
        if (!reset_n) begin
            w_gnt = 2'b00;
        end
    end

    assign w_sel     = w_gnt[1];
    assign r0Grant   = w_gnt[0];
    assign r1Grant   = w_gnt[1];

    assign memStrobe = |w_gnt;
    assign memAddr   = w_sel ? r1Addr  : r0Addr;
    assign memWData  = w_sel ? r1WData : r0WData;
    assign memWrite  = memStrobe & (w_sel ? r1Write : r0Write);

    assign r0Valid   = r_rsp_pending & (r_rsp_port == ARB_PORT_CPU);
    assign r1Valid   = r_rsp_pending & (r_rsp_port == ARB_PORT_LOADER);
    assign r0RData   = memDataRead;
    assign r1RData   = memDataRead;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_state  <= ARB_IDLE;
            r_last_grant  <= ARB_PORT_LOADER;
            r_rsp_pending <= 1'b0;
            r_rsp_port    <= ARB_PORT_CPU;
        end else begin
            r_rsp_pending <= memStrobe & ~memWrite;
            if (memStrobe) begin
                r_last_grant <= w_sel;
                r_rsp_port   <= w_sel;
            end
            case (r_lock_state)
                ARB_IDLE: begin
                    if (w_gnt[0] && r0Lock) begin
                        r_lock_state <= ARB_LOCK0;
                    end else if (w_gnt[1] && r1Lock) begin
                        r_lock_state <= ARB_LOCK1;
                    end
                end
                // Lock release ignores strobe so an idle owner can still let go.
                ARB_LOCK0: if (!r0Lock) r_lock_state <= ARB_IDLE;
                ARB_LOCK1: if (!r1Lock) r_lock_state <= ARB_IDLE;
                default:   r_lock_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, read-response scoreboard and reset/lock sequences.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       r0Strobe, r0Write, r0Lock, r0Grant, r0Valid;
    logic [7:0] r0Addr, r0WData, r0RData;
    logic       r1Strobe, r1Write, r1Lock, r1Grant, r1Valid;
    logic [7:0] r1Addr, r1WData, r1RData;
    logic [7:0] memAddr, memWData, memDataRead;
    logic       memStrobe, memWrite;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0Strobe(r0Strobe), .r0Addr(r0Addr), .r0Write(r0Write), .r0WData(r0WData),
        .r0Lock(r0Lock), .r0Grant(r0Grant), .r0Valid(r0Valid), .r0RData(r0RData),
        .r1Strobe(r1Strobe), .r1Addr(r1Addr), .r1Write(r1Write), .r1WData(r1WData),
        .r1Lock(r1Lock), .r1Grant(r1Grant), .r1Valid(r1Valid), .r1RData(r1RData),
        .memAddr(memAddr), .memStrobe(memStrobe), .memWrite(memWrite),
        .memWData(memWData), .memDataRead(memDataRead)
    );

    // Memory: read data appears the cycle after the strobe, writes commit at the edge.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (memStrobe) begin
            if (memWrite) mem[memAddr] <= memWData;
            else          memDataRead  <= mem[memAddr];
        end
    end

    typedef struct {
        logic       s0; logic [7:0] a0; logic w0; logic [7:0] d0; logic l0;
        logic       s1; logic [7:0] a1; logic w1; logic [7:0] d1; logic l1;
        logic       g0; logic g1;
    } vec_t;

    typedef struct {
        logic       vld;
        logic       port;
        logic [7:0] data;
    } rsp_t;

    logic [7:0] ref_mem [256];
    rsp_t       sbq [$];
    vec_t       tbl [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic vec_t v(input logic s0, input logic [7:0] a0, input logic w0,
                               input logic [7:0] d0, input logic l0,
                               input logic s1, input logic [7:0] a1, input logic w1,
                               input logic [7:0] d1, input logic l1,
                               input logic g0, input logic g1);
        vec_t r;
        r.s0 = s0; r.a0 = a0; r.w0 = w0; r.d0 = d0; r.l0 = l0;
        r.s1 = s1; r.a1 = a1; r.w1 = w1; r.d1 = d1; r.l1 = l1;
        r.g0 = g0; r.g1 = g1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        r0Strobe = x.s0; r0Addr = x.a0; r0Write = x.w0; r0WData = x.d0; r0Lock = x.l0;
        r1Strobe = x.s1; r1Addr = x.a1; r1Write = x.w1; r1WData = x.d1; r1Lock = x.l1;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t x);
        rsp_t e;
        rsp_t n;
        drive(x);
        @(negedge clk);
        chk("r0Grant", r0Grant, x.g0);
        chk("r1Grant", r1Grant, x.g1);
        chk("memStrobe", memStrobe, x.g0 | x.g1);
        if (x.g0 | x.g1) begin
            chk("memAddr", memAddr, x.g1 ? x.a1 : x.a0);
            chk("memWrite", memWrite, x.g1 ? x.w1 : x.w0);
            if (x.g1 ? x.w1 : x.w0) chk("memWData", memWData, x.g1 ? x.d1 : x.d0);
        end
        if (sbq.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sbq.pop_front();
            chk("r0Valid", r0Valid, e.vld && e.port == 1'b0);
            chk("r1Valid", r1Valid, e.vld && e.port == 1'b1);
            if (e.vld) chk("rdata", e.port ? r1RData : r0RData, e.data);
        end
        n.vld = 1'b0; n.port = 1'b0; n.data = 8'h00;
        if (x.g0 && !x.w0) begin n.vld = 1'b1; n.port = 1'b0; n.data = ref_mem[x.a0]; end
        if (x.g1 && !x.w1) begin n.vld = 1'b1; n.port = 1'b1; n.data = ref_mem[x.a1]; end
        sbq.push_back(n);
        if (x.g0 && x.w0) ref_mem[x.a0] = x.d0;
        if (x.g1 && x.w1) ref_mem[x.a1] = x.d1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_r0Grant", r0Grant, 1'b0);
        chk("rst_r1Grant", r1Grant, 1'b0);
        chk("rst_memStrobe", memStrobe, 1'b0);
        chk("rst_memWrite", memWrite, 1'b0);
        chk("rst_r0Valid", r0Valid, 1'b0);
        chk("rst_r1Valid", r1Valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic sb_restart();
        rsp_t n;
        n.vld = 1'b0; n.port = 1'b0; n.data = 8'h00;
        sbq.delete();
        sbq.push_back(n);
    endtask

    initial begin
        vec_t idle;
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end
        idle = v(0,8'h00,0,8'h00,0, 0,8'h00,0,8'h00,0, 0,0);

        // Reset with both ports strobing: nothing may be granted.
        reset_n = 1'b0;
        drive(v(1,8'h01,0,8'h00,0, 1,8'h02,1,8'h33,0, 0,0));
        @(posedge clk); #1;
        check_reset_outputs();
        check_reset_outputs();
        reset_n = 1'b1;
        sb_restart();

        // Contention: port 0 wins first, then strict alternation.
        tbl.push_back(v(1,8'h01,0,8'h00,0, 1,8'h81,0,8'h00,0, 1,0));
        tbl.push_back(v(1,8'h02,0,8'h00,0, 1,8'h81,0,8'h00,0, 0,1));
        tbl.push_back(v(1,8'h02,0,8'h00,0, 1,8'h82,0,8'h00,0, 1,0));
        tbl.push_back(v(1,8'h03,0,8'h00,0, 1,8'h82,0,8'h00,0, 0,1));
        tbl.push_back(v(1,8'h03,0,8'h00,0, 0,8'h00,0,8'h00,0, 1,0));
        // Write by port 1, read-back by port 0 the next cycle.
        tbl.push_back(v(0,8'h00,0,8'h00,0, 1,8'h20,1,8'hA5,0, 0,1));
        tbl.push_back(v(1,8'h20,0,8'h00,0, 0,8'h00,0,8'h00,0, 1,0));
        tbl.push_back(idle);
        // Port 1 locks for four cycles; port 0 stalls until the lock is released.
        tbl.push_back(v(1,8'h40,0,8'h00,0, 1,8'h30,0,8'h00,1, 0,1));
        tbl.push_back(v(1,8'h40,0,8'h00,0, 1,8'h31,0,8'h00,1, 0,1));
        tbl.push_back(v(1,8'h40,0,8'h00,0, 1,8'h32,0,8'h00,1, 0,1));
        tbl.push_back(v(1,8'h40,0,8'h00,0, 1,8'h33,0,8'h00,1, 0,1));
        tbl.push_back(v(1,8'h40,0,8'h00,0, 0,8'h00,0,8'h00,0, 0,0));
        tbl.push_back(v(1,8'h40,0,8'h00,0, 0,8'h00,0,8'h00,0, 1,0));
        // Port 0 locks, then releases on a cycle without a strobe.
        tbl.push_back(v(1,8'h50,0,8'h00,1, 0,8'h00,0,8'h00,0, 1,0));
        tbl.push_back(v(1,8'h51,0,8'h00,1, 1,8'h60,0,8'h00,0, 1,0));
        tbl.push_back(v(0,8'h00,0,8'h00,0, 1,8'h60,0,8'h00,0, 0,0));
        tbl.push_back(v(0,8'h00,0,8'h00,0, 1,8'h60,0,8'h00,0, 0,1));
        // Lock entry on a write still locks.
        tbl.push_back(v(0,8'h00,0,8'h00,0, 1,8'h61,1,8'h3C,1, 0,1));
        tbl.push_back(v(1,8'h61,0,8'h00,0, 1,8'h61,0,8'h00,0, 0,1));
        tbl.push_back(v(1,8'h61,0,8'h00,0, 0,8'h00,0,8'h00,0, 1,0));
        tbl.push_back(idle);
        foreach (tbl[i]) step(tbl[i]);

        // Port 0 alone streams all 256 addresses, wrapping without a stall.
        for (int i = 0; i < 258; i++) begin
            step(v(1,8'(i),0,8'h00,0, 0,8'h00,0,8'h00,0, 1,0));
        end
        step(idle);

        // Reset while a locked port-0 read response is outstanding.
        step(v(1,8'h10,0,8'h00,1, 0,8'h00,0,8'h00,0, 1,0));
        reset_n = 1'b0;
        drive(v(1,8'h11,0,8'h00,1, 1,8'h12,0,8'h00,0, 0,0));
        #1;
        chk("midrst_r0Valid", r0Valid, 1'b0);
        @(posedge clk); #1;
        check_reset_outputs();
        reset_n = 1'b1;
        sb_restart();
        step(idle);
        step(idle);
        step(v(0,8'h00,0,8'h00,0, 1,8'h12,0,8'h00,0, 0,1));
        step(v(1,8'h13,0,8'h00,0, 1,8'h14,0,8'h00,0, 1,0));
        step(idle);
        step(idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
